// File: rtl/mem_stage_pkg.sv
// Shared types and constants for the memory stage: FSM states and the MEM/WB record.
package mem_stage_pkg;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned REG_AW = 5;
    localparam logic [DATA_W-1:0] BUS_ERR_DATA = 32'hDEADBEEF;

    typedef enum logic {
        IDLE,
        BUSY
    } state_t;

    typedef struct packed {
        logic [DATA_W-1:0] read_data;
        logic [DATA_W-1:0] alu_result;
        logic [REG_AW-1:0] write_reg;
        logic              reg_write;
        logic              mem_to_reg;
        logic              bus_err;
        logic              misalign;
    } mem_wb_t;

endpackage

// File: rtl/mem_wb_reg.sv
// MEM/WB pipeline register. A bubble kills the control bits and flags and keeps the data
// fields; a load captures the whole record.
module mem_wb_reg
    import mem_stage_pkg::*;
(
    input  logic    clock,
    input  logic    reset,
    input  logic    load,
    input  logic    bubble,
    input  mem_wb_t d,
    output mem_wb_t q
);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            q <= '0;
        end else if (bubble) begin
            q.reg_write  <= 1'b0;
            q.mem_to_reg <= 1'b0;
            q.bus_err    <= 1'b0;
            q.misalign   <= 1'b0;
        end else if (load) begin
            q <= d;
        end
    end

endmodule

// File: rtl/mem_stage_ctrl.sv
// Memory stage controller: drives the data-memory req/ready handshake and feeds MEM/WB.
// Optional misaligned-access trap is enabled by defining MEM_MISALIGN_TRAP_EN.
module mem_stage_ctrl
    import mem_stage_pkg::*;
#(
    parameter int unsigned DMEM_AW        = 10,
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [31:0]        ALU_result_in,
    input  logic [31:0]        Rt_in,
    input  logic [4:0]         write_reg_num_in,
    input  logic               RegWrite_in,
    input  logic               MemWrite_in,
    input  logic               MemRead_in,
    input  logic               MemtoReg_in,
    input  logic [31:0]        dmem_rdata,
    input  logic               dmem_ready,
    output logic               dmem_req,
    output logic               dmem_we,
    output logic [DMEM_AW-1:0] dmem_addr,
    output logic [31:0]        dmem_wdata,
    output logic               stall,
    output logic [31:0]        read_data_out,
    output logic [31:0]        ALU_result_out,
    output logic [4:0]         write_reg_num_out,
    output logic               RegWriteout4,
    output logic               MemtoRegDout4,
    output logic               bus_err_out,
    output logic               misalign_out
);

    localparam int unsigned CntW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

    state_t             state_q, state_d;
    logic [CntW-1:0]    cnt_q, cnt_d;
    logic               req_q, req_d;
    logic               we_q, we_d;
    logic [DMEM_AW-1:0] addr_q, addr_d;
    logic [31:0]        wdata_q, wdata_d;

    logic    op, misaligned, issue, timeout_hit;
    logic    wb_load, wb_bubble;
    mem_wb_t wb_d, wb_q;

    assign op = MemRead_in | MemWrite_in;

`ifdef MEM_MISALIGN_TRAP_EN
    assign misaligned = op & (ALU_result_in[1:0] != 2'b00);
`else
    assign misaligned = 1'b0;
`endif

    assign issue       = (state_q == IDLE) & op & ~misaligned;
    assign timeout_hit = (TIMEOUT_CYCLES != 0) && (state_q == BUSY) && !dmem_ready
                         && (cnt_q == CntW'(TIMEOUT_CYCLES - 1));

    // Gated by reset so an abandoned access cannot hold the pipeline during reset.
    assign stall = reset & (issue | ((state_q == BUSY) & ~dmem_ready & ~timeout_hit));

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        req_d   = req_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;

        wb_load         = 1'b1;
        wb_bubble       = 1'b0;
        wb_d.read_data  = '0;
        wb_d.alu_result = ALU_result_in;
        wb_d.write_reg  = write_reg_num_in;
        wb_d.reg_write  = RegWrite_in;
        wb_d.mem_to_reg = MemtoReg_in;
        wb_d.bus_err    = 1'b0;
        wb_d.misalign   = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (issue) begin
                    state_d   = BUSY;
                    cnt_d     = '0;
                    req_d     = 1'b1;
                    we_d      = MemWrite_in;
                    addr_d    = ALU_result_in[DMEM_AW+1:2];
                    wdata_d   = Rt_in;
                    wb_bubble = 1'b1;
                end else if (misaligned) begin
                    wb_d.reg_write  = 1'b0;
                    wb_d.mem_to_reg = 1'b0;
                    wb_d.misalign   = 1'b1;
                end
            end
            BUSY: begin
                if (dmem_ready) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    req_d   = 1'b0;
                    if (!we_q) begin
                        wb_d.read_data = dmem_rdata;
                    end
                end else if (timeout_hit) begin
                    state_d        = IDLE;
                    cnt_d          = '0;
                    req_d          = 1'b0;
                    wb_d.read_data = BUS_ERR_DATA;
                    wb_d.reg_write = 1'b0;
                    wb_d.bus_err   = 1'b1;
                end else begin
                    cnt_d     = cnt_q + 1'b1;
                    wb_bubble = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            req_q   <= req_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
        end
    end

    mem_wb_reg u_mem_wb_reg (
        .clock  (clock),
        .reset  (reset),
        .load   (wb_load),
        .bubble (wb_bubble),
        .d      (wb_d),
        .q      (wb_q)
    );

    assign dmem_req          = req_q;
    assign dmem_we           = we_q;
    assign dmem_addr         = addr_q;
    assign dmem_wdata        = wdata_q;
    assign read_data_out     = wb_q.read_data;
    assign ALU_result_out    = wb_q.alu_result;
    assign write_reg_num_out = wb_q.write_reg;
    assign RegWriteout4      = wb_q.reg_write;
    assign MemtoRegDout4     = wb_q.mem_to_reg;
    assign bus_err_out       = wb_q.bus_err;
    assign misalign_out      = wb_q.misalign;

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Scoreboard bench for mem_stage_ctrl: directed cases, then randomized instructions whose
// expected MEM/WB records are queued by the stimulus and checked by an independent monitor.
module tb_mem_stage_ctrl;

    localparam int unsigned AW = 10;
    localparam int unsigned TO = 4;

    logic          clock, reset;
    logic [31:0]   ALU_result_in, Rt_in, dmem_rdata;
    logic [4:0]    write_reg_num_in;
    logic          RegWrite_in, MemWrite_in, MemRead_in, MemtoReg_in, dmem_ready;
    logic          dmem_req, dmem_we, stall;
    logic [AW-1:0] dmem_addr;
    logic [31:0]   dmem_wdata, read_data_out, ALU_result_out;
    logic [4:0]    write_reg_num_out;
    logic          RegWriteout4, MemtoRegDout4, bus_err_out, misalign_out;

    mem_stage_ctrl #(
        .DMEM_AW        (AW),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clock             (clock),
        .reset             (reset),
        .ALU_result_in     (ALU_result_in),
        .Rt_in             (Rt_in),
        .write_reg_num_in  (write_reg_num_in),
        .RegWrite_in       (RegWrite_in),
        .MemWrite_in       (MemWrite_in),
        .MemRead_in        (MemRead_in),
        .MemtoReg_in       (MemtoReg_in),
        .dmem_rdata        (dmem_rdata),
        .dmem_ready        (dmem_ready),
        .dmem_req          (dmem_req),
        .dmem_we           (dmem_we),
        .dmem_addr         (dmem_addr),
        .dmem_wdata        (dmem_wdata),
        .stall             (stall),
        .read_data_out     (read_data_out),
        .ALU_result_out    (ALU_result_out),
        .write_reg_num_out (write_reg_num_out),
        .RegWriteout4      (RegWriteout4),
        .MemtoRegDout4     (MemtoRegDout4),
        .bus_err_out       (bus_err_out),
        .misalign_out      (misalign_out)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    typedef struct {
        logic [31:0] rd;
        logic [31:0] alu;
        logic [4:0]  wr;
        logic        rw;
        logic        mtr;
        logic        err;
        logic        mis;
    } rec_t;

    rec_t        exp_q[$];
    rec_t        last;
    bit          mon_en    = 0;
    bit          have_prev = 0;
    logic        prev_stall;
    logic [AW-1:0] cur_addr;
    logic        cur_we;
    logic [31:0] cur_wdata;

    // Monitor: an unstalled cycle retires one instruction into MEM/WB; a stalled one is a bubble.
    always @(negedge clock) begin
        rec_t e;
        if (mon_en) begin
            if (have_prev) begin
                if (prev_stall) begin
                    check("bubble RegWriteout4", {31'd0, RegWriteout4}, 32'd0);
                    check("bubble MemtoRegDout4", {31'd0, MemtoRegDout4}, 32'd0);
                    check("bubble flags", {30'd0, bus_err_out, misalign_out}, 32'd0);
                    check("bubble ALU_result_out hold", ALU_result_out, last.alu);
                    check("bubble read_data_out hold", read_data_out, last.rd);
                end else if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL retire: MEM/WB write with no instruction expected (t=%0t)",
                             $time);
                end else begin
                    e = exp_q.pop_front();
                    check("read_data_out", read_data_out, e.rd);
                    check("ALU_result_out", ALU_result_out, e.alu);
                    check("write_reg_num_out", {27'd0, write_reg_num_out}, {27'd0, e.wr});
                    check("RegWriteout4", {31'd0, RegWriteout4}, {31'd0, e.rw});
                    check("MemtoRegDout4", {31'd0, MemtoRegDout4}, {31'd0, e.mtr});
                    check("bus_err_out", {31'd0, bus_err_out}, {31'd0, e.err});
                    check("misalign_out", {31'd0, misalign_out}, {31'd0, e.mis});
                    last = e;
                end
            end
            prev_stall = stall;
            have_prev  = 1;
        end
    end

    // One clock: check stall and the memory port mid-cycle, then advance past the edge.
    task automatic cycle(input logic exp_stall, input logic exp_busy);
        @(negedge clock);
        check("stall", {31'd0, stall}, {31'd0, exp_stall});
        check("dmem_req", {31'd0, dmem_req}, {31'd0, exp_busy});
        if (exp_busy) begin
            check("dmem_addr", {22'd0, dmem_addr}, {22'd0, cur_addr});
            check("dmem_we", {31'd0, dmem_we}, {31'd0, cur_we});
            check("dmem_wdata", dmem_wdata, cur_wdata);
        end
        @(posedge clock);
        #1;
    endtask

    // Issues one instruction; d is the BUSY cycle on which memory answers (beyond TO: never).
    task automatic do_instr(input bit rd, input bit wr, input logic [31:0] alu,
                            input logic [31:0] rt, input logic [4:0] wrn, input bit rw,
                            input bit mtr, input int d, input logic [31:0] rdata);
        rec_t e;
        bit   mis;
        mis = 0;
`ifdef MEM_MISALIGN_TRAP_EN
        mis = (rd | wr) && (alu[1:0] != 2'b00);
`endif
        MemRead_in       = rd;
        MemWrite_in      = wr;
        ALU_result_in    = alu;
        Rt_in            = rt;
        write_reg_num_in = wrn;
        RegWrite_in      = rw;
        MemtoReg_in      = mtr;
        dmem_ready       = 1'($urandom_range(0, 1));  // must be ignored outside BUSY
        dmem_rdata       = $urandom;
        e.alu = alu;
        e.wr  = wrn;
        e.rw  = rw;
        e.mtr = mtr;
        e.rd  = 32'd0;
        e.err = 1'b0;
        e.mis = 1'b0;
        if (!(rd | wr) || mis) begin
            if (mis) begin
                e.rw  = 1'b0;
                e.mtr = 1'b0;
                e.mis = 1'b1;
            end
            exp_q.push_back(e);
            cycle(1'b0, 1'b0);
        end else begin
            cur_addr  = alu[AW+1:2];
            cur_we    = wr;
            cur_wdata = rt;
            cycle(1'b1, 1'b0);
            for (int i = 1; i <= int'(TO); i++) begin
                if (i == d) begin
                    dmem_ready = 1'b1;
                    dmem_rdata = rdata;
                    if (!wr) e.rd = rdata;
                    exp_q.push_back(e);
                    cycle(1'b0, 1'b1);
                    break;
                end else if (i == int'(TO)) begin
                    dmem_ready = 1'b0;
                    dmem_rdata = $urandom;
                    e.rd  = 32'hDEADBEEF;
                    e.rw  = 1'b0;
                    e.err = 1'b1;
                    exp_q.push_back(e);
                    cycle(1'b0, 1'b1);
                    break;
                end else begin
                    dmem_ready = 1'b0;
                    dmem_rdata = $urandom;
                    cycle(1'b1, 1'b1);
                end
            end
        end
        dmem_ready = 1'b0;
    endtask

    initial begin
        reset            = 1'b0;
        ALU_result_in    = '0;
        Rt_in            = '0;
        write_reg_num_in = '0;
        RegWrite_in      = 1'b0;
        MemWrite_in      = 1'b0;
        MemRead_in       = 1'b0;
        MemtoReg_in      = 1'b0;
        dmem_rdata       = '0;
        dmem_ready       = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        check("reset dmem_req", {31'd0, dmem_req}, 32'd0);
        check("reset dmem_addr", {22'd0, dmem_addr}, 32'd0);
        check("reset dmem_wdata", dmem_wdata, 32'd0);
        check("reset stall", {31'd0, stall}, 32'd0);
        check("reset read_data_out", read_data_out, 32'd0);
        check("reset ALU_result_out", ALU_result_out, 32'd0);
        @(negedge clock) reset = 1'b1;
        @(posedge clock);
        #1;

        // Load abandoned by reset in its first BUSY cycle.
        MemRead_in    = 1'b1;
        ALU_result_in = 32'h100;
        RegWrite_in   = 1'b1;
        @(posedge clock);
        #1;
        check("busy dmem_req", {31'd0, dmem_req}, 32'd1);
        #3 reset = 1'b0;
        #1;
        check("midreset dmem_req", {31'd0, dmem_req}, 32'd0);
        check("midreset stall", {31'd0, stall}, 32'd0);
        check("midreset dmem_addr", {22'd0, dmem_addr}, 32'd0);
        check("midreset dmem_we", {31'd0, dmem_we}, 32'd0);
        check("midreset outputs",
              {25'd0, write_reg_num_out, RegWriteout4, MemtoRegDout4}, 32'd0);
        check("midreset flags", {30'd0, bus_err_out, misalign_out}, 32'd0);
        MemRead_in  = 1'b0;
        RegWrite_in = 1'b0;
        @(negedge clock) reset = 1'b1;
        @(posedge clock);
        #1;

        mon_en = 1;
        do_instr(0, 0, 32'h5, 32'h0, 5'd3, 1, 0, 0, 32'h0);
        check("post-reset ALU_result_out", ALU_result_out, 32'h5);
        check("post-reset RegWriteout4", {31'd0, RegWriteout4}, 32'd1);

        do_instr(1, 0, 32'h40, 32'h0, 5'd7, 1, 1, 3, 32'hCAFEF00D);
        do_instr(0, 1, 32'h8, 32'h1234, 5'd0, 0, 0, 1, 32'h0);
        do_instr(1, 0, 32'h80, 32'h0, 5'd9, 1, 1, TO + 5, 32'h0);
        do_instr(0, 0, 32'h77, 32'h0, 5'd4, 1, 0, 0, 32'h0);
        do_instr(1, 1, 32'h24, 32'hA5A5, 5'd2, 0, 0, 2, 32'h13572468);
        do_instr(1, 0, 32'h10, 32'h0, 5'd5, 1, 1, 1, 32'h11111111);
        do_instr(1, 0, 32'h14, 32'h0, 5'd6, 1, 1, 1, 32'h22222222);
        do_instr(1, 0, 32'h18, 32'h0, 5'd8, 1, 1, TO, 32'h33333333);
        do_instr(1, 0, 32'h41, 32'h0, 5'd1, 1, 1, 2, 32'h44444444);

        for (int n = 0; n < 300; n++) begin
            int          kind;
            logic [31:0] a;
            kind = $urandom_range(0, 3);
            a    = $urandom;
            if ($urandom_range(0, 3) != 0) a[1:0] = 2'b00;
            do_instr(kind == 1 || kind == 3, kind == 2 || kind == 3, a, $urandom,
                     5'($urandom), 1'($urandom), 1'($urandom), $urandom_range(1, TO + 2),
                     $urandom);
        end

        do_instr(0, 0, 32'h0, 32'h0, 5'd0, 0, 0, 0, 32'h0);
        @(negedge clock);
        #1;
        check("scoreboard drained", exp_q.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
